vfpu_stream_sequencer: RTL and testbench



---
 rtl/vfpu_stream_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_vfpu_stream_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfpu_stream_sequencer.sv
// Job-level sequencer for the VFPU engine: handshakes job start with the
// operand source and result sink streamers, counts result beats, collects
// per-streamer done flags and reports completion, length mismatch and
// watchdog timeout.
module vfpu_stream_sequencer #(
  parameter int NB_OPERANDS = 2,
  parameter int LEN_WIDTH   = 16,
  parameter int TO_WIDTH    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  input  logic [TO_WIDTH-1:0]    timeout_i,
  input  logic [NB_OPERANDS-1:0] src_ready_start_i,
  input  logic [NB_OPERANDS-1:0] src_done_i,
  input  logic                   sink_ready_start_i,
  input  logic                   sink_done_i,
  input  logic                   res_valid_i,
  input  logic                   res_ready_i,
  output logic [NB_OPERANDS-1:0] src_req_start_o,
  output logic                   sink_req_start_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_count_o,
  output logic                   err_timeout_o,
  output logic [LEN_WIDTH-1:0]   elem_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_START    = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TO_WIDTH-1:0]  WD_ONE  = {{(TO_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r, state_s;
  logic [LEN_WIDTH-1:0]   len_r, len_s;
  logic [LEN_WIDTH-1:0]   elem_cnt_r, elem_cnt_s;
  logic [TO_WIDTH-1:0]    wd_r, wd_s;
  logic [NB_OPERANDS-1:0] src_lat_r, src_lat_s;
  logic                   sink_lat_r, sink_lat_s;
  logic                   err_count_r, err_count_s;
  logic                   err_timeout_r, err_timeout_s;

  logic                   hs_s;
  logic                   all_rdy_s;
  logic [NB_OPERANDS-1:0] src_lat_upd_s;
  logic                   sink_lat_upd_s;
  logic                   all_done_s;
  logic [LEN_WIDTH-1:0]   elem_run_s;
  logic [TO_WIDTH-1:0]    wd_inc_s;
  logic                   wd_hit_s;

  assign hs_s           = res_valid_i & res_ready_i;
  assign all_rdy_s      = (&src_ready_start_i) & sink_ready_start_i;
  // Done flags may be single-cycle pulses, so completion looks at the
  // latches including anything arriving this cycle.
  assign src_lat_upd_s  = src_lat_r | src_done_i;
  assign sink_lat_upd_s = sink_lat_r | sink_done_i;
  assign all_done_s     = (&src_lat_upd_s) & sink_lat_upd_s;
  // Beat counter saturates instead of wrapping so a runaway stream still
  // reads as a mismatch.
  assign elem_run_s     = (hs_s && (elem_cnt_r != '1)) ? (elem_cnt_r + LEN_ONE) : elem_cnt_r;
  assign wd_inc_s       = wd_r + WD_ONE;
  assign wd_hit_s       = (timeout_i != '0) && (wd_inc_s == timeout_i);

  assign err_count_o    = err_count_r;
  assign err_timeout_o  = err_timeout_r;
  assign elem_cnt_o     = elem_cnt_r;

  // Next-state, counter, latch and error-flag computation.
  always_comb begin
    state_s       = state_r;
    len_s         = len_r;
    elem_cnt_s    = elem_cnt_r;
    wd_s          = wd_r;
    src_lat_s     = src_lat_r;
    sink_lat_s    = sink_lat_r;
    err_count_s   = err_count_r;
    err_timeout_s = err_timeout_r;
    if (abort_i) begin
      // Abort wins over everything; results of the job stay visible.
      state_s = ST_IDLE;
      wd_s    = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wd_s = '0;
          if (start_i) begin
            len_s         = len_i;
            elem_cnt_s    = '0;
            err_count_s   = 1'b0;
            err_timeout_s = 1'b0;
            src_lat_s     = '0;
            sink_lat_s    = 1'b0;
            if (len_i == '0) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_WAIT_RDY;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT_RDY: begin
          if (all_rdy_s) begin
            state_s = ST_START;
            wd_s    = '0;
          end else if (wd_hit_s) begin
            state_s       = ST_ERROR;
            err_timeout_s = 1'b1;
            wd_s          = '0;
          end else begin
            wd_s = wd_inc_s;
          end
        end
        ST_START: begin
          src_lat_s  = src_lat_upd_s;
          sink_lat_s = sink_lat_upd_s;
          wd_s       = '0;
          state_s    = ST_RUN;
        end
        ST_RUN: begin
          src_lat_s  = src_lat_upd_s;
          sink_lat_s = sink_lat_upd_s;
          elem_cnt_s = elem_run_s;
          if (all_done_s) begin
            // Completion takes precedence over a watchdog expiring in the same cycle.
            state_s     = ST_DONE;
            wd_s        = '0;
            err_count_s = (elem_run_s != len_r);
          end else if (hs_s) begin
            wd_s = '0;
          end else if (wd_hit_s) begin
            state_s       = ST_ERROR;
            err_timeout_s = 1'b1;
            wd_s          = '0;
          end else begin
            wd_s = wd_inc_s;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        ST_ERROR: begin
          state_s = ST_ERROR;
        end
        default: begin
          state_s = ST_IDLE;
          wd_s    = '0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs, with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r          <= ST_IDLE;
      len_r            <= '0;
      elem_cnt_r       <= '0;
      wd_r             <= '0;
      src_lat_r        <= '0;
      sink_lat_r       <= 1'b0;
      err_count_r      <= 1'b0;
      err_timeout_r    <= 1'b0;
      src_req_start_o  <= '0;
      sink_req_start_o <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
    end else begin
      state_r          <= state_s;
      len_r            <= len_s;
      elem_cnt_r       <= elem_cnt_s;
      wd_r             <= wd_s;
      src_lat_r        <= src_lat_s;
      sink_lat_r       <= sink_lat_s;
      err_count_r      <= err_count_s;
      err_timeout_r    <= err_timeout_s;
      src_req_start_o  <= (state_s == ST_START) ? '1 : '0;
      sink_req_start_o <= (state_s == ST_START);
      busy_o           <= (state_s != ST_IDLE);
      done_o           <= (state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_vfpu_stream_sequencer.sv
// Directed self-checking bench for vfpu_stream_sequencer.
module tb_vfpu_stream_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] len;
  logic [15:0] timeout;
  logic [1:0]  src_ready;
  logic [1:0]  src_done;
  logic        sink_ready;
  logic        sink_done;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  src_req;
  logic        sink_req;
  logic        busy;
  logic        done;
  logic        err_count;
  logic        err_timeout;
  logic [15:0] elem_cnt;

  int checks   = 0;
  int failures = 0;
  int req_cnt  = 0;
  int done_cnt = 0;
  int snap     = 0;

  vfpu_stream_sequencer #(
    .NB_OPERANDS(2),
    .LEN_WIDTH  (16),
    .TO_WIDTH   (16)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .abort_i           (abort),
    .len_i             (len),
    .timeout_i         (timeout),
    .src_ready_start_i (src_ready),
    .src_done_i        (src_done),
    .sink_ready_start_i(sink_ready),
    .sink_done_i       (sink_done),
    .res_valid_i       (res_valid),
    .res_ready_i       (res_ready),
    .src_req_start_o   (src_req),
    .sink_req_start_o  (sink_req),
    .busy_o            (busy),
    .done_o            (done),
    .err_count_o       (err_count),
    .err_timeout_o     (err_timeout),
    .elem_cnt_o        (elem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count req_start and done pulses over the whole run.
  always @(posedge clk) begin
    if (sink_req === 1'b1) req_cnt <= req_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; len = 16'd0; timeout = 16'd0;
    src_ready = 2'b00; src_done = 2'b00; sink_ready = 1'b0; sink_done = 1'b0;
    res_valid = 1'b0; res_ready = 1'b0;
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_src_req", src_req, 0);
    chk("rst_sink_req", sink_req, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_elem_cnt", elem_cnt, 0);
    rst = 1'b0;
    step(1);

    // Normal job: len 8, readies high
    src_ready = 2'b11; sink_ready = 1'b1; len = 16'd8; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t1_busy_wait", busy, 1);
    chk("t1_req_wait", src_req, 0);
    step(1);
    chk("t1_src_req", src_req, 2'b11);
    chk("t1_sink_req", sink_req, 1);
    step(1);
    chk("t1_req_off", src_req, 0);
    res_valid = 1'b1; res_ready = 1'b1;
    step(8);
    chk("t1_elem_8", elem_cnt, 8);
    chk("t1_no_done_yet", done, 0);
    res_valid = 1'b0; res_ready = 1'b0; src_done = 2'b11; sink_done = 1'b1;
    step(1);
    src_done = 2'b00; sink_done = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_err_count", err_count, 0);
    chk("t1_elem", elem_cnt, 8);
    step(1);
    chk("t1_done_off", done, 0);
    chk("t1_idle", busy, 0);

    // Ready delay: sink ready low for 5 cycles after start
    snap = req_cnt;
    sink_ready = 1'b0; len = 16'd2; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t2_no_req", sink_req, 0);
    end
    sink_ready = 1'b1;
    step(1);
    chk("t2_src_req", src_req, 2'b11);
    chk("t2_sink_req", sink_req, 1);
    step(1);
    chk("t2_req_off", sink_req, 0);
    res_valid = 1'b1; res_ready = 1'b1;
    step(2);
    res_valid = 1'b0; res_ready = 1'b0; src_done = 2'b11; sink_done = 1'b1;
    step(1);
    src_done = 2'b00; sink_done = 1'b0;
    chk("t2_done", done, 1);
    chk("t2_elem", elem_cnt, 2);
    step(1);
    chk("t2_req_once", req_cnt - snap, 1);

    // Mismatch: len 4, 3 handshakes, staggered done flags
    len = 16'd4; start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    res_valid = 1'b1; res_ready = 1'b0;
    step(1);
    chk("t3_valid_only", elem_cnt, 0);
    res_ready = 1'b1;
    step(3);
    res_valid = 1'b0; res_ready = 1'b0; src_done = 2'b01;
    step(1);
    chk("t3_partial_done", done, 0);
    src_done = 2'b10; sink_done = 1'b1;
    step(1);
    src_done = 2'b00; sink_done = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_err_count", err_count, 1);
    chk("t3_elem", elem_cnt, 3);
    step(1);
    chk("t3_err_sticky", err_count, 1);
    chk("t3_idle", busy, 0);

    // Timeout: no handshakes in RUN
    snap = done_cnt;
    timeout = 16'd10; len = 16'd4; start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    step(9);
    chk("t4_no_to_yet", err_timeout, 0);
    chk("t4_err_count_cleared", err_count, 0);
    step(1);
    chk("t4_timeout", err_timeout, 1);
    chk("t4_busy_err", busy, 1);
    step(3);
    chk("t4_still_busy", busy, 1);
    chk("t4_no_done", done_cnt - snap, 0);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t4_abort_idle", busy, 0);
    chk("t4_to_held", err_timeout, 1);
    timeout = 16'd0;

    // Zero length job
    snap = req_cnt;
    len = 16'd0; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t5_zero_done", done, 1);
    chk("t5_zero_to_clr", err_timeout, 0);
    chk("t5_zero_err", err_count, 0);
    step(1);
    chk("t5_zero_done_off", done, 0);
    chk("t5_zero_no_req", req_cnt - snap, 0);

    // Start during RUN is ignored
    snap = done_cnt;
    len = 16'd8; start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    start = 1'b1; len = 16'd3; res_valid = 1'b1; res_ready = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    res_valid = 1'b0; res_ready = 1'b0; src_done = 2'b11; sink_done = 1'b1;
    step(1);
    src_done = 2'b00; sink_done = 1'b0;
    chk("t5_busy_done", done, 1);
    chk("t5_busy_elem", elem_cnt, 8);
    chk("t5_busy_err", err_count, 0);
    step(2);
    chk("t5_single_done", done_cnt - snap, 1);

    // Reset mid-RUN, then a job with done flags during START
    len = 16'd5; start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    res_valid = 1'b1; res_ready = 1'b1;
    step(2);
    chk("t6_pre_rst_elem", elem_cnt, 2);
    rst = 1'b1;
    step(1);
    rst = 1'b0; res_valid = 1'b0; res_ready = 1'b0;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_elem", elem_cnt, 0);
    chk("t6_rst_req", src_req, 0);
    chk("t6_rst_done", done, 0);
    len = 16'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    chk("t6_start", sink_req, 1);
    src_done = 2'b11;
    step(1);
    src_done = 2'b00;
    chk("t6_src_only", done, 0);
    res_valid = 1'b1; res_ready = 1'b1;
    step(1);
    res_valid = 1'b0; res_ready = 1'b0; sink_done = 1'b1;
    step(1);
    sink_done = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_elem", elem_cnt, 1);
    chk("t6_err", err_count, 0);
    step(1);
    chk("t6_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
